data_sram_arb: RTL and testbench
================================

DATA_SRAM_ARB -- requirements
Module: data_sram_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive load/store grants taken while wb_req is pending before the write buffer is forced to win.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 flush  in  1  pipeline flush; cancels the load/store requester's outstanding or pending access.
REQ-005 stall_mem  in  1  mem stage held; any load/store response is buffered while high.
REQ-006 ls_req / ls_wr / ls_size / ls_addr / ls_wstrb / ls_wdata  in  1/1/2/32/4/32  load/store request, held by the pipeline until ls_rvalid.
REQ-007 ls_rdata  out  32  load result, registered; ls_rvalid  out  1  one-cycle response pulse.
REQ-008 stallreq  out  1  stall request to the pipeline while a load/store is unfinished.
REQ-009 wb_req / wb_addr / wb_wstrb / wb_wdata  in  1/32/4/32  write-buffer drain request (word stores only); wb_ack  out  1  one-cycle completion pulse.
REQ-010 data_req / data_wr / data_size / data_addr / data_wstrb / data_wdata  out  1/1/2/32/4/32  SRAM-like master request.
REQ-011 data_addr_ok / data_data_ok  in  1/1  slave handshakes; data_rdata  in  32  read data valid with data_data_ok.

Function
REQ-012 FSM states IDLE, ADDR, WAIT, RESP; at most one transaction outstanding.
REQ-013 IDLE grant: LS wins if ls_req=1, flush=0, and (wb_req=0 or starve_cnt<STARVE_MAX); otherwise WB wins if wb_req=1; a grant latches owner and all request fields and moves to ADDR.
REQ-014 Field muxing: LS grant uses ls_* as given; WB grant uses data_wr=1, data_size=2'b10, wb_addr/wb_wstrb/wb_wdata.
REQ-015 starve_cnt, 3 bits, saturating: increments on an LS grant while wb_req=1; clears on any WB grant.
REQ-016 data_req=1 exactly while in ADDR, driven from registers; data_* outputs stay stable until data_addr_ok is sampled high.
REQ-017 ADDR with data_addr_ok=1 -> WAIT; data_data_ok is ignored in every state except WAIT.
REQ-018 WAIT with data_data_ok=1 and owner WB -> wb_ack=1 that cycle, then IDLE.
REQ-019 WAIT with data_data_ok=1 and owner LS, not dropped -> data_rdata captured into rdata_buf (0 for stores), then RESP.
REQ-020 WAIT with data_data_ok=1 and owner LS, dropped -> IDLE, with no ls_rvalid.
REQ-021 RESP: ls_rvalid = ~stall_mem and ls_rdata = rdata_buf; leave to IDLE in the cycle ls_rvalid=1; hold indefinitely while stall_mem=1.
REQ-022 Flush while owner LS in ADDR or WAIT sets the drop flag; the request is not retracted, and data_req stays high until data_addr_ok.
REQ-023 Flush in RESP: immediate return to IDLE, no ls_rvalid.
REQ-024 The drop flag clears on entry to IDLE.
REQ-025 Flush never affects a WB-owned transaction.
REQ-026 stallreq = ls_req & ~flush & ~ls_rvalid; it is combinational, so it is high during grant, ADDR, WAIT and RESP-with-stall.
REQ-027 Minimum load latency from LS grant cycle T: data_req at T+1; with zero-wait slave, data_ok at T+2; ls_rvalid at T+3.
REQ-028 No LS grant in the cycle ls_rvalid=1; a new ls_req is eligible in the following IDLE cycle.
REQ-029 Address alignment and exceptions are not checked; the upstream stage filters them.

Reset
REQ-030 resetn=0 at a rising edge forces IDLE, owner=LS, drop=0, starve_cnt=0, rdata_buf=0, and all latched fields to 0.
REQ-031 During reset all outputs are 0: data_req, ls_rvalid, wb_ack, stallreq, ls_rdata.
REQ-032 Reset mid-transaction abandons it; a subsequent stray data_data_ok in IDLE is ignored.

Verification
REQ-033 LW: ls_req=1, ls_addr=0x1000, zero-wait slave, rdata=0xDEADBEEF -> data_req at T+1; ls_rvalid=1 and ls_rdata=0xDEADBEEF at T+3; stallreq=0 at T+3.
REQ-034 The REQ-033 load with stall_mem=1 during T+3..T+5 -> ls_rvalid=0 through T+5; ls_rvalid=1 at T+6 with 0xDEADBEEF; data_req stays single.
REQ-035 ls_req and wb_req held continuously -> grant order LS,LS,LS,LS,WB,LS...; wb_ack once per WB transaction with data_size=2'b10.
REQ-036 Flush one cycle after LS grant with data_addr_ok delayed 3 cycles -> data_req held until addr_ok; no ls_rvalid; FSM returns to IDLE after data_ok.
REQ-037 resetn=0 in WAIT, then data_data_ok=1 after release -> all outputs 0, FSM stays IDLE, no ls_rvalid or wb_ack.

Source files
------------

// File: rtl/data_sram_arb.sv
// Arbitrates the data SRAM-like master port between the load/store pipeline and the write buffer.
// One transaction in flight; loads get priority until the write buffer has waited STARVE_MAX grants.
module data_sram_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        stall_mem,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [3:0]  ls_wstrb,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_rvalid,
  output logic        stallreq,
  input  logic        wb_req,
  input  logic [31:0] wb_addr,
  input  logic [3:0]  wb_wstrb,
  input  logic [31:0] wb_wdata,
  output logic        wb_ack,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  localparam logic [31:0] STARVE_LIM = STARVE_MAX;

  state_t      state_reg, state_next;
  logic        owner_wb_reg;
  logic        drop_reg;
  logic [2:0]  starve_cnt_reg;
  logic [31:0] rdata_buf_reg;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] wdata_reg;

  logic ls_win;
  logic wb_win;
  logic dropped;
  logic rvalid;

  assign ls_win  = ls_req & ~flush & (~wb_req | (32'(starve_cnt_reg) < STARVE_LIM));
  assign wb_win  = ~ls_win & wb_req;
  // A flush arriving in the same cycle as data_ok still cancels the load.
  assign dropped = drop_reg | flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ls_win || wb_win) state_next = ADDR;
      ADDR: if (data_addr_ok) state_next = WAIT;
      WAIT: begin
        if (data_data_ok) begin
          state_next = (owner_wb_reg || dropped) ? IDLE : RESP;
        end
      end
      RESP: if (flush || !stall_mem) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_wb_reg   <= 1'b0;
      drop_reg       <= 1'b0;
      starve_cnt_reg <= 3'd0;
      rdata_buf_reg  <= 32'd0;
      wr_reg         <= 1'b0;
      size_reg       <= 2'd0;
      addr_reg       <= 32'd0;
      wstrb_reg      <= 4'd0;
      wdata_reg      <= 32'd0;
    end else begin
      if (state_reg == IDLE && ls_win) begin
        owner_wb_reg <= 1'b0;
        wr_reg       <= ls_wr;
        size_reg     <= ls_size;
        addr_reg     <= ls_addr;
        wstrb_reg    <= ls_wstrb;
        wdata_reg    <= ls_wdata;
        if (wb_req && starve_cnt_reg != 3'd7) begin
          starve_cnt_reg <= starve_cnt_reg + 3'd1;
        end
      end else if (state_reg == IDLE && wb_win) begin
        owner_wb_reg   <= 1'b1;
        wr_reg         <= 1'b1;
        size_reg       <= 2'b10;
        addr_reg       <= wb_addr;
        wstrb_reg      <= wb_wstrb;
        wdata_reg      <= wb_wdata;
        starve_cnt_reg <= 3'd0;
      end

      if (state_next == IDLE) begin
        drop_reg <= 1'b0;
      end else if (!owner_wb_reg && flush && (state_reg == ADDR || state_reg == WAIT)) begin
        drop_reg <= 1'b1;
      end

      if (state_reg == WAIT && data_data_ok && !owner_wb_reg && !dropped) begin
        rdata_buf_reg <= wr_reg ? 32'd0 : data_rdata;
      end
    end
  end

  // Handshake outputs are gated by resetn so they read 0 throughout reset.
  always_comb begin
    rvalid     = resetn & (state_reg == RESP) & ~stall_mem & ~flush;
    ls_rvalid  = rvalid;
    ls_rdata   = resetn ? rdata_buf_reg : 32'd0;
    stallreq   = resetn & ls_req & ~flush & ~rvalid;
    wb_ack     = resetn & (state_reg == WAIT) & data_data_ok & owner_wb_reg;
    data_req   = resetn & (state_reg == ADDR);
    data_wr    = wr_reg;
    data_size  = size_reg;
    data_addr  = addr_reg;
    data_wstrb = wstrb_reg;
    data_wdata = wdata_reg;
  end

endmodule

// File: tb/tb_data_sram_arb.sv
// Bench for data_sram_arb: behavioural SRAM-like slave, request and response scoreboards,
// cycle-level checks for load latency, stall, arbitration fairness, flush and reset.
module tb_data_sram_arb;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        stall_mem;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_rvalid;
  logic        stallreq;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic [3:0]  wb_wstrb;
  logic [31:0] wb_wdata;
  logic        wb_ack;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int errors = 0;

  // Expected master requests {wstrb, wr, size, addr} and expected load responses.
  logic [38:0] exp_req_q[$];
  logic [31:0] exp_rdata_q[$];

  int          addr_delay  = 0;
  logic        hold_data   = 1'b0;
  logic        force_dok   = 1'b0;
  logic [31:0] slave_rdata = 32'd0;
  int          req_cycles  = 0;
  int          acc_cnt     = 0;
  int          wb_ack_cnt  = 0;

  data_sram_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall_mem(stall_mem),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wstrb(ls_wstrb), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_rvalid(ls_rvalid), .stallreq(stallreq),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wstrb(wb_wstrb), .wb_wdata(wb_wdata),
    .wb_ack(wb_ack),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave: addr_ok after addr_delay waiting cycles, data_ok the cycle after acceptance.
  initial begin
    logic accepted;
    int   addr_cnt;
    logic [38:0] exp;
    accepted = 1'b0;
    addr_cnt = 0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        accepted = 1'b0;
        addr_cnt = 0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'd0;
      end else begin
        if (accepted && !hold_data) begin
          data_data_ok = 1'b1;
          data_rdata = slave_rdata;
          accepted = 1'b0;
        end else begin
          data_data_ok = force_dok;
          data_rdata = force_dok ? 32'hBAD0BAD0 : 32'd0;
        end
        data_addr_ok = 1'b0;
        if (data_req) begin
          req_cycles++;
          if (addr_cnt >= addr_delay) begin
            data_addr_ok = 1'b1;
            addr_cnt = 0;
            accepted = 1'b1;
            acc_cnt++;
            $display("req accepted: wr=%0d size=%0d addr=%h wstrb=%h",
                     data_wr, data_size, data_addr, data_wstrb);
            if (exp_req_q.size() == 0) begin
              check("req_unexpected", 64'(1), 64'(0));
            end else begin
              exp = exp_req_q.pop_front();
              check("req_fields", 64'({data_wstrb, data_wr, data_size, data_addr}), 64'(exp));
            end
          end else begin
            addr_cnt++;
          end
        end else begin
          addr_cnt = 0;
        end
      end
    end
  end

  // Response monitor: every ls_rvalid must match the head of the expected-data queue.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (ls_rvalid) begin
        $display("ls resp: rdata=%h", ls_rdata);
        if (exp_rdata_q.size() == 0) begin
          check("rvalid_unexpected", 64'(1), 64'(0));
        end else begin
          exp = exp_rdata_q.pop_front();
          check("rvalid_data", 64'(ls_rdata), 64'(exp));
        end
      end
      if (wb_ack) begin
        wb_ack_cnt++;
        $display("wb ack");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Single LS access on a zero-wait slave, with stall_n stalled RESP cycles.
  task automatic do_ls(input logic wr, input logic [31:0] addr, input logic [31:0] sdata,
                       input int stall_n);
    int r0;
    r0 = req_cycles;
    @(negedge clk);
    ls_req = 1'b1;
    ls_wr = wr;
    ls_size = 2'b10;
    ls_addr = addr;
    ls_wstrb = wr ? 4'hF : 4'h0;
    ls_wdata = ~addr;
    slave_rdata = sdata;
    exp_req_q.push_back({ls_wstrb, wr, 2'b10, addr});
    exp_rdata_q.push_back(wr ? 32'd0 : sdata);
    #1;
    check("grant_stallreq", 64'(stallreq), 64'(1));
    check("grant_no_req", 64'(data_req), 64'(0));
    @(negedge clk); #1;
    check("t1_data_req", 64'(data_req), 64'(1));
    check("t1_data_addr", 64'(data_addr), 64'(addr));
    @(negedge clk); #1;
    check("t2_data_req", 64'(data_req), 64'(0));
    check("t2_rvalid", 64'(ls_rvalid), 64'(0));
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      stall_mem = 1'b1;
      #1;
      check("stall_rvalid", 64'(ls_rvalid), 64'(0));
      check("stall_stallreq", 64'(stallreq), 64'(1));
    end
    @(negedge clk);
    stall_mem = 1'b0;
    #1;
    check("resp_rvalid", 64'(ls_rvalid), 64'(1));
    check("resp_rdata", 64'(ls_rdata), 64'(wr ? 32'd0 : sdata));
    check("resp_stallreq", 64'(stallreq), 64'(0));
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    check("after_rvalid", 64'(ls_rvalid), 64'(0));
    check("single_req", 64'(req_cycles - r0), 64'(1));
  endtask

  initial begin
    int  a0;
    int  r0;
    logic done;
    resetn = 1'b0; flush = 1'b0; stall_mem = 1'b0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'd0;
    ls_wstrb = 4'd0; ls_wdata = 32'd0;
    wb_req = 1'b0; wb_addr = 32'd0; wb_wstrb = 4'd0; wb_wdata = 32'd0;

    // Reset: outputs forced low even with ls_req asserted.
    repeat (2) @(negedge clk);
    #1;
    check("rst_data_req", 64'(data_req), 64'(0));
    check("rst_rvalid", 64'(ls_rvalid), 64'(0));
    check("rst_wb_ack", 64'(wb_ack), 64'(0));
    check("rst_stallreq", 64'(stallreq), 64'(0));
    check("rst_rdata", 64'(ls_rdata), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    ls_req = 1'b0;
    @(negedge clk);

    do_ls(1'b0, 32'h0000_1000, 32'hDEADBEEF, 0);
    do_ls(1'b0, 32'h0000_1000, 32'hDEADBEEF, 3);
    do_ls(1'b1, 32'h0000_1100, 32'h5555_AAAA, 0);

    // Both requesters held: LS x4, then forced WB, then LS.
    slave_rdata = 32'h1234_5678;
    wb_ack_cnt = 0;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) exp_req_q.push_back({4'h0, 1'b0, 2'b01, 32'h0000_2000});
    exp_req_q.push_back({4'hF, 1'b1, 2'b10, 32'h0000_3000});
    exp_req_q.push_back({4'h0, 1'b0, 2'b01, 32'h0000_2000});
    for (int i = 0; i < 5; i++) exp_rdata_q.push_back(32'h1234_5678);
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b01; ls_addr = 32'h0000_2000; ls_wstrb = 4'h0;
    wb_req = 1'b1; wb_addr = 32'h0000_3000; wb_wstrb = 4'hF; wb_wdata = 32'hCAFE_F00D;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt - a0 >= 6) wb_req = 1'b0;
      #1;
      if (acc_cnt - a0 >= 6 && ls_rvalid) begin
        done = 1'b1;
        break;
      end
    end
    check("arb_done", 64'(done), 64'(1));
    @(negedge clk);
    ls_req = 1'b0;
    ls_size = 2'b10;
    @(negedge clk); #1;
    check("arb_wb_acks", 64'(wb_ack_cnt), 64'(1));

    // Flush one cycle after grant, addr_ok delayed 3 cycles.
    addr_delay = 3;
    r0 = req_cycles;
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h0000_4000; ls_wstrb = 4'h0;
    exp_req_q.push_back({4'h0, 1'b0, 2'b10, 32'h0000_4000});
    @(negedge clk);
    flush = 1'b1;
    ls_req = 1'b0;
    #1;
    check("flush_data_req", 64'(data_req), 64'(1));
    check("flush_stallreq", 64'(stallreq), 64'(0));
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("flush_req_held", 64'(data_req), 64'(1));
      @(negedge clk);
    end
    #1;
    check("flush_req_done", 64'(data_req), 64'(0));
    repeat (4) @(negedge clk);
    check("flush_req_cycles", 64'(req_cycles - r0), 64'(4));
    addr_delay = 0;
    do_ls(1'b0, 32'h0000_4400, 32'h0BAD_CAFE, 0);

    // Reset while waiting for data_ok, then a stray data_ok after release.
    hold_data = 1'b1;
    @(negedge clk);
    ls_req = 1'b1; ls_addr = 32'h0000_5000;
    exp_req_q.push_back({4'h0, 1'b0, 2'b10, 32'h0000_5000});
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_wait_stallreq", 64'(stallreq), 64'(0));
    check("rst_wait_rdata", 64'(ls_rdata), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    ls_req = 1'b0;
    hold_data = 1'b0;
    #1;
    check("rst_rel_data_req", 64'(data_req), 64'(0));
    @(negedge clk);
    force_dok = 1'b1;
    @(negedge clk);
    force_dok = 1'b0;
    #1;
    check("stray_dok_seen", 64'(data_data_ok), 64'(1));
    check("stray_rvalid", 64'(ls_rvalid), 64'(0));
    check("stray_wb_ack", 64'(wb_ack), 64'(0));
    check("stray_data_req", 64'(data_req), 64'(0));
    @(negedge clk); #1;
    check("stray_idle_req", 64'(data_req), 64'(0));
    do_ls(1'b0, 32'h0000_6000, 32'h600D_D00D, 0);

    repeat (3) @(negedge clk);
    check("req_q_empty", 64'(exp_req_q.size()), 64'(0));
    check("rdata_q_empty", 64'(exp_rdata_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
